// File: rtl/seven_seg_scan.sv
// Time-multiplexed hex display driver: scans DIGITS nibbles onto one 7-segment bus, frame-synchronous load.
// Optional leading-zero blanking when SEVEN_SEG_LZ_BLANK_EN is defined; seg/an are registered (1-cycle latency).
module seven_seg_scan #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic                  load,
  output logic                  load_pending,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0]     CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0]     IDX_MAX = IW'(DIGITS - 1);
  localparam logic [6:0]        SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{ACTIVE_LOW}};

  logic [CW-1:0]         count_q, count_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   shadow_q, shadow_d;
  logic [4*DIGITS-1:0]   disp_q, disp_d;
  logic                  pend_q, pend_d;
  logic [6:0]            seg_q, seg_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic                  tick, frame_end, blank;
  logic [3:0]            nib;
  logic [DIGITS-1:0]     an_hi;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  assign tick      = (count_q == CNT_MAX);
  assign frame_end = tick && (idx_q == IDX_MAX);

  always_comb begin
    count_d = tick ? '0 : count_q + 1'b1;
    idx_d   = idx_q;
    if (tick) idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
  end

  // A load on the frame boundary bypasses the shadow so it is never left pending.
  always_comb begin
    shadow_d = shadow_q;
    disp_d   = disp_q;
    pend_d   = pend_q;
    if (load && frame_end) begin
      shadow_d = value_in;
      disp_d   = value_in;
      pend_d   = 1'b0;
    end else if (load) begin
      shadow_d = value_in;
      pend_d   = 1'b1;
    end else if (frame_end && pend_q) begin
      disp_d   = shadow_q;
      pend_d   = 1'b0;
    end
  end

`ifdef SEVEN_SEG_LZ_BLANK_EN
  logic [IW-1:0] msd;
  // Highest nonzero nibble; stays 0 for an all-zero value so digit 0 never blanks.
  always_comb begin
    msd = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (disp_q[4*k +: 4] != 4'h0) msd = IW'(k);
    end
  end
  assign blank = (idx_q > msd);
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    nib   = disp_q[{idx_q, 2'b00} +: 4];
    an_hi = {{(DIGITS-1){1'b0}}, 1'b1} << idx_q;
    seg_d = SEG_OFF;
    an_d  = AN_OFF;
    if (!blank) begin
      seg_d = ACTIVE_LOW ? ~hex7(nib) : hex7(nib);
      an_d  = ACTIVE_LOW ? ~an_hi : an_hi;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      disp_q   <= '0;
      pend_q   <= 1'b0;
      seg_q    <= SEG_OFF;
      an_q     <= AN_OFF;
    end else begin
      count_q  <= count_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      disp_q   <= disp_d;
      pend_q   <= pend_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign load_pending = pend_q;
  assign seg          = seg_q;
  assign an           = an_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan with DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=1: directed table plus random loads/resets
// checked every cycle against a frame-time reference model.
module tb_seven_seg_scan;
  localparam int D = 4;
  localparam int R = 4;
`ifdef SEVEN_SEG_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, load, load_pending;
  logic [15:0] value_in;
  logic [6:0]  seg;
  logic [3:0]  an;

  seven_seg_scan #(.DIGITS(D), .REFRESH_DIV(R), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .value_in(value_in), .load(load),
    .load_pending(load_pending), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: time within the frame, plus the values the display holds.
  int          m_t = 0;
  logic [15:0] m_disp = '0, m_shadow = '0;
  logic        m_pend = 1'b0;
  logic [6:0]  dec [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (model t=%0d)", name, act, exp, m_t);
    end
  endtask

  function automatic int top_digit(input logic [15:0] v);
    int top = 0;
    for (int k = 0; k < D; k++) if (((v >> (4*k)) & 16'hF) != 0) top = k;
    return top;
  endfunction

  task automatic step(input logic r, input logic l, input logic [15:0] v);
    logic [6:0] e_seg;
    logic [3:0] e_an;
    int slot;
    rst = r; load = l; value_in = v;
    if (r) begin
      e_seg = 7'h7F; e_an = 4'hF;
    end else begin
      slot = (m_t / R) % D;
      if (LZ && slot > top_digit(m_disp)) begin
        e_seg = 7'h7F; e_an = 4'hF;
      end else begin
        e_seg = ~dec[(m_disp >> (4*slot)) & 16'hF];
        e_an  = ~(4'b0001 << slot);
      end
    end
    if (r) begin
      m_t = 0; m_disp = '0; m_shadow = '0; m_pend = 1'b0;
    end else begin
      if (l && m_t == R*D-1) begin
        m_disp = v; m_shadow = v; m_pend = 1'b0;
      end else if (l) begin
        m_shadow = v; m_pend = 1'b1;
      end else if (m_t == R*D-1 && m_pend) begin
        m_disp = m_shadow; m_pend = 1'b0;
      end
      m_t = (m_t + 1) % (R*D);
    end
    @(posedge clk);
    @(negedge clk);
    check("model_seg", 16'(seg), 16'(e_seg));
    check("model_an", 16'(an), 16'(e_an));
    check("model_pend", 16'(load_pending), 16'(m_pend));
  endtask

  task automatic goto(input int tgt);
    for (int i = 0; i < 2*R*D && m_t != tgt; i++) step(1'b0, 1'b0, 16'h0);
    if (m_t != tgt) begin
      tests++; fails++;
      $display("FAIL goto: model t=%0d, wanted %0d", m_t, tgt);
    end
  endtask

  // Observe slot k of the current frame: step from its second cycle.
  task automatic peek_slot(input int k);
    goto(k*R + 1);
    step(1'b0, 1'b0, 16'h0);
  endtask

  typedef struct {
    logic [15:0]      val;
    logic [3:0][6:0]  s;
    logic [3:0][3:0]  a;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{16'h1A2F, {7'h79, 7'h08, 7'h24, 7'h0E}, {4'h7, 4'hB, 4'hD, 4'hE}};
    vecs[1] = '{16'h89B4, {7'h00, 7'h10, 7'h03, 7'h19}, {4'h7, 4'hB, 4'hD, 4'hE}};
    vecs[2] = '{16'h6E7D, {7'h02, 7'h06, 7'h78, 7'h21}, {4'h7, 4'hB, 4'hD, 4'hE}};
    if (LZ) vecs[3] = '{16'h0005, {7'h7F, 7'h7F, 7'h7F, 7'h12}, {4'hF, 4'hF, 4'hF, 4'hE}};
    else    vecs[3] = '{16'h0005, {7'h40, 7'h40, 7'h40, 7'h12}, {4'h7, 4'hB, 4'hD, 4'hE}};

    // Reset, then slot 0 shows "0".
    step(1'b1, 1'b1, 16'hFFFF);
    check("rst_seg", 16'(seg), 16'h7F);
    check("rst_an", 16'(an), 16'hF);
    step(1'b0, 1'b0, 16'h0);
    check("post_rst_seg", 16'(seg), 16'h40);
    check("post_rst_an", 16'(an), 16'hE);

    // Table: load mid-frame, pending until frame end, then scan the next frame.
    foreach (vecs[i]) begin
      goto(5);
      step(1'b0, 1'b1, vecs[i].val);
      check("tbl_pend_set", 16'(load_pending), 16'h1);
      goto(15);
      check("tbl_pend_hold", 16'(load_pending), 16'h1);
      step(1'b0, 1'b0, 16'h0);
      check("tbl_pend_clr", 16'(load_pending), 16'h0);
      for (int k = 0; k < D; k++) begin
        peek_slot(k);
        check("tbl_seg", 16'(seg), 16'(vecs[i].s[k]));
        check("tbl_an", 16'(an), 16'(vecs[i].a[k]));
      end
    end

    // Last of two loads in a frame wins; 1111 never shows.
    goto(2);
    step(1'b0, 1'b1, 16'h1111);
    goto(7);
    step(1'b0, 1'b1, 16'h2222);
    goto(0);
    for (int k = 0; k < D; k++) begin
      peek_slot(k);
      check("last_wins_seg", 16'(seg), 16'h24);
    end

    // Load exactly on the frame_end cycle goes straight to the display.
    goto(15);
    step(1'b0, 1'b1, 16'h00C3);
    check("fe_load_pend", 16'(load_pending), 16'h0);
    peek_slot(0);
    check("fe_load_seg0", 16'(seg), 16'h30);

    // Load held for three cycles with changing data.
    goto(2);
    step(1'b0, 1'b1, 16'h4444);
    step(1'b0, 1'b1, 16'h5555);
    step(1'b0, 1'b1, 16'h3333);
    goto(0);
    peek_slot(0);
    check("held_load_seg0", 16'(seg), 16'h30);

    // Mid-frame reset discards a pending value.
    goto(5);
    step(1'b0, 1'b1, 16'h9999);
    step(1'b1, 1'b0, 16'h0);
    check("midrst_an", 16'(an), 16'hF);
    check("midrst_pend", 16'(load_pending), 16'h0);
    step(1'b0, 1'b0, 16'h0);
    check("midrst_seg0", 16'(seg), 16'h40);
    check("midrst_an0", 16'(an), 16'hE);
    goto(0);
    peek_slot(0);
    check("midrst_discard", 16'(seg), 16'h40);

    // Random loads and occasional resets against the model.
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0, 16'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
